// File: rtl/exe_stage_module.sv
// Execute stage: Val2 generation, ALU with NZCV flags, branch target, and the
// EX/MEM pipeline register plus the status register.
module exe_stage_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_enable_in,
  input  logic        mem_read_enable_in,
  input  logic        mem_write_enable_in,
  input  logic        branch_enable_in,
  input  logic        S_in,
  input  logic        immidiate,
  input  logic [3:0]  exec_cmd,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_immidiate_24,
  input  logic [3:0]  Dest_in,
  input  logic [3:0]  Status_in,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [3:0]  Status,
  output logic        wb_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] ALU_result,
  output logic [31:0] Val_Rm_out,
  output logic [3:0]  Dest
);

  localparam int unsigned DW = 32;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  logic [DW-1:0]   val2;
  logic [DW-1:0]   imm_ext;
  logic [4:0]      imm_rot;
  logic [4:0]      sh_amt;
  logic [2*DW-1:0] rot_tmp;
  logic [DW:0]     sum;
  logic [DW-1:0]   alu_res_d;
  logic [3:0]      nzcv_d;
  logic            c_in;

  logic            wb_q, mr_q, mw_q;
  logic [DW-1:0]   alu_q, rm_q;
  logic [3:0]      dest_q, status_q;

  // Second operand: rotated immediate, raw 12-bit memory offset, or shifted Rm.
  always_comb begin
    val2    = '0;
    rot_tmp = '0;
    imm_ext = {24'b0, Shift_operand[7:0]};
    imm_rot = {Shift_operand[11:8], 1'b0};
    sh_amt  = Shift_operand[11:7];
    if (immidiate) begin
      rot_tmp = {imm_ext, imm_ext} >> imm_rot;
      val2    = rot_tmp[DW-1:0];
    end else if (mem_read_enable_in || mem_write_enable_in) begin
      val2 = {20'b0, Shift_operand[11:0]};
    end else begin
      case (Shift_operand[6:5])
        2'b00: val2 = Val_Rm << sh_amt;
        2'b01: val2 = Val_Rm >> sh_amt;
        2'b10: val2 = DW'($signed(Val_Rm) >>> sh_amt);
        default: begin
          rot_tmp = {Val_Rm, Val_Rm} >> sh_amt;
          val2    = rot_tmp[DW-1:0];
        end
      endcase
    end
  end

  // ALU and next flags; subtraction is Rn + ~Val2 + carry so C is NOT borrow.
  always_comb begin
    alu_res_d = '0;
    nzcv_d    = Status_in;
    sum       = '0;
    c_in      = Status_in[1];
    case (exec_cmd)
      OP_MOV, OP_MVN, OP_AND, OP_ORR, OP_EOR: begin
        case (exec_cmd)
          OP_MOV:  alu_res_d = val2;
          OP_MVN:  alu_res_d = ~val2;
          OP_AND:  alu_res_d = Val_Rn & val2;
          OP_ORR:  alu_res_d = Val_Rn | val2;
          default: alu_res_d = Val_Rn ^ val2;
        endcase
        nzcv_d = {alu_res_d[DW-1], alu_res_d == '0, Status_in[1:0]};
      end
      OP_ADD, OP_ADC: begin
        sum = {1'b0, Val_Rn} + {1'b0, val2}
            + {32'b0, (exec_cmd == OP_ADC) ? c_in : 1'b0};
        alu_res_d = sum[DW-1:0];
        nzcv_d = {alu_res_d[DW-1], alu_res_d == '0, sum[DW],
                  (Val_Rn[DW-1] == val2[DW-1]) && (alu_res_d[DW-1] != Val_Rn[DW-1])};
      end
      OP_SUB, OP_SBC: begin
        sum = {1'b0, Val_Rn} + {1'b0, ~val2}
            + {32'b0, (exec_cmd == OP_SBC) ? c_in : 1'b1};
        alu_res_d = sum[DW-1:0];
        nzcv_d = {alu_res_d[DW-1], alu_res_d == '0, sum[DW],
                  (Val_Rn[DW-1] != val2[DW-1]) && (alu_res_d[DW-1] != Val_Rn[DW-1])};
      end
      default: ;
    endcase
  end

  assign branch_taken   = branch_enable_in;
  assign branch_address = PC_in + {{6{Signed_immidiate_24[23]}}, Signed_immidiate_24, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
    end else if (S_in && !freeze) begin
      status_q <= nzcv_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      alu_q  <= '0;
      rm_q   <= '0;
      dest_q <= '0;
    end else if (!freeze) begin
      wb_q   <= wb_enable_in;
      mr_q   <= mem_read_enable_in;
      mw_q   <= mem_write_enable_in;
      alu_q  <= alu_res_d;
      rm_q   <= Val_Rm;
      dest_q <= Dest_in;
    end
  end

  assign Status           = status_q;
  assign wb_enable        = wb_q;
  assign mem_read_enable  = mr_q;
  assign mem_write_enable = mw_q;
  assign ALU_result       = alu_q;
  assign Val_Rm_out       = rm_q;
  assign Dest             = dest_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// Directed bench for exe_stage_module with hand-computed expected values.
module tb_exe_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_enable_in, mem_read_enable_in, mem_write_enable_in;
  logic        branch_enable_in, S_in, immidiate;
  logic [3:0]  exec_cmd;
  logic [31:0] PC_in, Val_Rn, Val_Rm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_immidiate_24;
  logic [3:0]  Dest_in, Status_in;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  Status;
  logic        wb_enable, mem_read_enable, mem_write_enable;
  logic [31:0] ALU_result, Val_Rm_out;
  logic [3:0]  Dest;

  int tests = 0;
  int errors = 0;

  exe_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_enable_in(wb_enable_in), .mem_read_enable_in(mem_read_enable_in),
    .mem_write_enable_in(mem_write_enable_in), .branch_enable_in(branch_enable_in),
    .S_in(S_in), .immidiate(immidiate), .exec_cmd(exec_cmd),
    .PC_in(PC_in), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
    .Shift_operand(Shift_operand), .Signed_immidiate_24(Signed_immidiate_24),
    .Dest_in(Dest_in), .Status_in(Status_in),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .Status(Status), .wb_enable(wb_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .ALU_result(ALU_result),
    .Val_Rm_out(Val_Rm_out), .Dest(Dest)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    freeze = 0; wb_enable_in = 0; mem_read_enable_in = 0; mem_write_enable_in = 0;
    branch_enable_in = 0; S_in = 0; immidiate = 0; exec_cmd = 4'b0000;
    PC_in = 0; Val_Rn = 0; Val_Rm = 0; Shift_operand = 0;
    Signed_immidiate_24 = 0; Dest_in = 0; Status_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string name, input logic [31:0] exp_res, input logic [3:0] exp_st);
    // wraps the two inline comparisons each ALU scenario needs
    tests++;
    if (ALU_result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, ALU_result, exp_res);
    end
    tests++;
    if (Status !== exp_st) begin
      errors++;
      $display("FAIL %s status: got %b expected %b", name, Status, exp_st);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #3;
    tests++;
    if ({Status, wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm_out, Dest} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%b res=%h rm=%h dest=%h", Status, ALU_result, Val_Rm_out, Dest);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_sub();
    clear_inputs();
    exec_cmd = 4'b0010; Val_Rn = 32'h7FFF_FFFF; immidiate = 1; Shift_operand = 12'h001; S_in = 1;
    step();
    check_res("add_overflow", 32'h8000_0000, 4'b1001);
    clear_inputs();
    exec_cmd = 4'b0100; Val_Rn = 5; immidiate = 1; Shift_operand = 12'h005; S_in = 1;
    step();
    check_res("sub_zero", 32'h0, 4'b0110);
    clear_inputs();
    exec_cmd = 4'b0011; Val_Rn = 1; immidiate = 1; Shift_operand = 12'h002; Status_in = 4'b0010; S_in = 1;
    step();
    check_res("adc_carry_in", 32'h4, 4'b0000);
    clear_inputs();
    exec_cmd = 4'b0101; Val_Rn = 5; immidiate = 1; Shift_operand = 12'h002; Status_in = 4'b0000; S_in = 1;
    step();
    check_res("sbc_borrow", 32'h2, 4'b0010);
    clear_inputs();
    exec_cmd = 4'b0100; Val_Rn = 2; immidiate = 1; Shift_operand = 12'h003; S_in = 1;
    step();
    check_res("sub_negative", 32'hFFFF_FFFF, 4'b1000);
  endtask

  task automatic test_val2();
    clear_inputs();
    exec_cmd = 4'b0001; immidiate = 1; Shift_operand = 12'h1FF;
    step();
    check_res("mov_imm_rotate", 32'hC000_003F, 4'b1000);
    clear_inputs();
    exec_cmd = 4'b0001; Val_Rm = 32'h8000_0000; Shift_operand = 12'h240;
    step();
    check_res("mov_asr4", 32'hF800_0000, 4'b1000);
    clear_inputs();
    exec_cmd = 4'b0001; Val_Rm = 32'h0000_0001; Shift_operand = 12'h200;
    step();
    check_res("mov_lsl4", 32'h0000_0010, 4'b1000);
    clear_inputs();
    exec_cmd = 4'b0001; Val_Rm = 32'h8000_0000; Shift_operand = 12'h220;
    step();
    check_res("mov_lsr4", 32'h0800_0000, 4'b1000);
    clear_inputs();
    exec_cmd = 4'b0001; Val_Rm = 32'h0000_0001; Shift_operand = 12'h0E0;
    step();
    check_res("mov_ror1", 32'h8000_0000, 4'b1000);
    clear_inputs();
    exec_cmd = 4'b0001; Val_Rm = 32'h1234_5678; Shift_operand = 12'h060;
    step();
    check_res("mov_ror0", 32'h1234_5678, 4'b1000);
  endtask

  task automatic test_mem_path();
    clear_inputs();
    exec_cmd = 4'b0010; Val_Rn = 32'h1000; Val_Rm = 32'hDEAD_BEEF; Shift_operand = 12'hABC;
    mem_read_enable_in = 1; wb_enable_in = 1; Dest_in = 4'hA;
    step();
    check_res("mem_offset", 32'h0000_1ABC, 4'b1000);
    tests++;
    if ({wb_enable, mem_read_enable, mem_write_enable, Val_Rm_out, Dest} !== {3'b110, 32'hDEAD_BEEF, 4'hA}) begin
      errors++;
      $display("FAIL mem_ctrl: got wb=%b mr=%b mw=%b rm=%h dest=%h expected 1 1 0 deadbeef a",
               wb_enable, mem_read_enable, mem_write_enable, Val_Rm_out, Dest);
    end
  endtask

  task automatic test_logic();
    clear_inputs();
    exec_cmd = 4'b0110; Val_Rn = 32'h0000_F0F0; immidiate = 1; Shift_operand = 12'h0FF;
    Status_in = 4'b0011; S_in = 1;
    step();
    check_res("and_keep_cv", 32'h0000_00F0, 4'b0011);
    clear_inputs();
    exec_cmd = 4'b1001; immidiate = 1; Shift_operand = 12'h000; Status_in = 4'b0010; S_in = 1;
    step();
    check_res("mvn_zero", 32'hFFFF_FFFF, 4'b1010);
    clear_inputs();
    exec_cmd = 4'b0111; Val_Rn = 32'hF000_0000; immidiate = 1; Shift_operand = 12'h00F; S_in = 1;
    step();
    check_res("orr", 32'hF000_000F, 4'b1000);
    clear_inputs();
    exec_cmd = 4'b1000; Val_Rn = 32'h0000_00AA; immidiate = 1; Shift_operand = 12'h0AA; S_in = 1;
    step();
    check_res("eor_zero", 32'h0, 4'b0100);
    clear_inputs();
    exec_cmd = 4'b1111; Val_Rn = 32'h1234; immidiate = 1; Shift_operand = 12'h001;
    Status_in = 4'b1010; S_in = 1;
    step();
    check_res("invalid_op", 32'h0, 4'b1010);
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_enable_in = 1; PC_in = 32'h100; Signed_immidiate_24 = 24'hFFFFFE;
    #1;
    tests++;
    if ({branch_taken, branch_address} !== {1'b1, 32'h0000_00F8}) begin
      errors++;
      $display("FAIL branch_back: got %b %h expected 1 000000f8", branch_taken, branch_address);
    end
    branch_enable_in = 0; PC_in = 32'hFFFF_FFF0; Signed_immidiate_24 = 24'h000008;
    #1;
    tests++;
    if ({branch_taken, branch_address} !== {1'b0, 32'h0000_0010}) begin
      errors++;
      $display("FAIL branch_wrap: got %b %h expected 0 00000010", branch_taken, branch_address);
    end
  endtask

  task automatic test_freeze();
    clear_inputs();
    exec_cmd = 4'b0001; immidiate = 1; Shift_operand = 12'h055; S_in = 1;
    wb_enable_in = 1; Dest_in = 4'h3; Val_Rm = 32'h11;
    step();
    check_res("pre_freeze", 32'h55, 4'b0000);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      exec_cmd = 4'b1001; Shift_operand = 12'(i); Dest_in = 4'(i + 7); Val_Rm = 32'(i + 100);
      wb_enable_in = 0; mem_write_enable_in = 1;
      step();
      check_res("frozen", 32'h55, 4'b0000);
      tests++;
      if ({wb_enable, mem_write_enable, Dest, Val_Rm_out} !== {2'b10, 4'h3, 32'h11}) begin
        errors++;
        $display("FAIL frozen_ctrl cycle %0d: got wb=%b mw=%b dest=%h rm=%h expected 1 0 3 00000011",
                 i, wb_enable, mem_write_enable, Dest, Val_Rm_out);
      end
    end
    branch_enable_in = 1; PC_in = 32'h200; Signed_immidiate_24 = 24'h000001;
    #1;
    tests++;
    if ({branch_taken, branch_address} !== {1'b1, 32'h0000_0204}) begin
      errors++;
      $display("FAIL branch_in_freeze: got %b %h expected 1 00000204", branch_taken, branch_address);
    end
    rst = 0;
    #1;
    tests++;
    if ({Status, wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm_out, Dest} !== '0) begin
      errors++;
      $display("FAIL reset_in_freeze: got st=%b wb=%b res=%h rm=%h dest=%h",
               Status, wb_enable, ALU_result, Val_Rm_out, Dest);
    end
    step();
    tests++;
    if (ALU_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 00000000", ALU_result);
    end
    @(negedge clk);
    rst = 1; freeze = 0;
    exec_cmd = 4'b0010; Val_Rn = 32'h10; immidiate = 1; Shift_operand = 12'h020; S_in = 0;
    step();
    check_res("first_after_reset", 32'h30, 4'b0000);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_add_sub();
    test_val2();
    test_mem_path();
    test_logic();
    test_branch();
    test_freeze();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_module.md
EXE_STAGE_MODULE -- requirements
Module: exe_stage_module

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port freeze  input  1  hold EX/MEM register and status register.
REQ-004 SHALL have ports wb_enable_in, mem_read_enable_in, mem_write_enable_in, branch_enable_in, S_in, immidiate  input  1 each  control bits from ID/EX register.
REQ-005 SHALL have port exec_cmd  input  4  ALU opcode.
REQ-006 SHALL have ports PC_in, Val_Rn, Val_Rm  input  32 each  PC+4 of instruction, operand values.
REQ-007 SHALL have ports Shift_operand  input  12, Signed_immidiate_24  input  24, Dest_in  input  4, Status_in  input  4 (NZCV; [3]=N [2]=Z [1]=C [0]=V).
REQ-008 SHALL have ports branch_taken  output  1, branch_address  output  32  combinational, to IF stage.
REQ-009 SHALL have port Status  output  4  registered NZCV, fed back to ID stage status_in.
REQ-010 SHALL have registered outputs wb_enable, mem_read_enable, mem_write_enable  output  1 each; ALU_result  output  32; Val_Rm_out  output  32; Dest  output  4.

Function
REQ-011 SHALL generate Val2: immidiate=1 -> zero-extended Shift_operand[7:0] rotated right by 2*Shift_operand[11:8]; rotate 0 -> unrotated.
REQ-012 SHALL, immidiate=0 and (mem_read_enable_in|mem_write_enable_in), use Val2 = zero-extended Shift_operand[11:0].
REQ-013 SHALL otherwise shift Val_Rm by Shift_operand[11:7], type Shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; amount 0 -> Val_Rm unchanged.
REQ-014 SHALL compute ALU per exec_cmd: 0001 MOV Val2; 1001 MVN ~Val2; 0010 ADD Rn+Val2; 0011 ADC Rn+Val2+C; 0100 SUB Rn-Val2; 0101 SBC Rn-Val2-(~C); 0110 AND; 0111 ORR; 1000 EOR; other codes -> result 0, flags unchanged.
REQ-015 SHALL take C for ADC/SBC from Status_in[1].
REQ-016 SHALL set N=result[31], Z=(result==0); C=carry-out of 33-bit add, or NOT borrow for SUB/SBC; V=signed overflow for add/sub; logic/move ops keep C and V from Status_in.
REQ-017 SHALL drive branch_taken = branch_enable_in, branch_address = PC_in + (sign-extended Signed_immidiate_24 << 2), mod 2^32, same cycle.
REQ-018 SHALL load internal status register with new NZCV on clk edge when S_in=1 and freeze=0; else hold.
REQ-019 SHALL load EX/MEM register (control bits, ALU_result, Val_Rm_out=Val_Rm, Dest=Dest_in) every clk edge with freeze=0; freeze=1 -> all held, branch outputs still combinational.
REQ-020 SHALL give latency of exactly one clock from inputs to registered outputs.
REQ-021 SHALL wrap arithmetic at 32 bits; no exceptions or saturation.

Reset
REQ-022 SHALL, rst=0, asynchronously clear Status, wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm_out, Dest to 0 regardless of clk/freeze.
REQ-023 SHALL, reset asserted mid-operation, discard in-flight result; first capture at first rising edge after rst=1.
REQ-024 SHALL, rst=0 with freeze=1, still clear; reset dominates freeze.

Verification
REQ-025 ADD, Val_Rn=0x7FFFFFFF, imm Val2=1, S_in=1 -> ALU_result=0x80000000, Status=1001 next cycle.
REQ-026 SUB, Val_Rn=5, Val2=5, S_in=1 -> ALU_result=0, Status=0110 (Z=1, C=1).
REQ-027 immidiate=1, Shift_operand=0x1FF, MOV -> Val2=0xC000003F rotated by 2 -> ALU_result=0xC000003F.
REQ-028 Val_Rm=0x80000000, Shift_operand[11:5]={5'd4,2'b10}, MOV -> ALU_result=0xF8000000.
REQ-029 branch_enable_in=1, PC_in=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_address=0xF8 same cycle.
REQ-030 freeze=1 for 3 cycles with changing inputs -> registered outputs and Status constant; rst=0 during freeze -> all outputs 0 immediately.
